inst_rom_loader: RTL and testbench

//   Responder end of the CPU instruction-fetch interface (rom_en/rom_addr -> rom_inst).

---
 rtl/inst_rom_loader.sv | 147 ++++++++++++++
 tb/tb_inst_rom_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
// Instruction ROM: combinational 0-cycle fetch; boot loader writes 1 byte/cycle, big-endian.
// The loader stalls indefinitely on ld_valid low, and ld_ready is high only while in LOAD.
`timescale 1ns/1ps
module inst_rom_loader #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_en,
  input  logic [31:0]       rom_addr,
  output logic [INST_W-1:0] rom_inst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic              cpu_hold
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] word_ptr_q, word_ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [23:0]       asm_q, asm_d;
  logic              ld_ready_q, ld_ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;

  logic [INST_W-1:0] mem [DEPTH];

  logic              accept;
  logic              word_wr;
  logic              last_word;
  logic [INST_W-1:0] wr_word;
  logic [ADDR_W-1:0] widx;
  logic              addr_in_range;
  logic              unused_addr_bits;

  assign accept    = (state_q == LOAD) && ld_valid && ld_ready_q;
  assign word_wr   = accept && (byte_cnt_q == 2'd3);
  assign last_word = word_wr && ({1'b0, word_ptr_q} == (len_q - ONE_L));
  assign wr_word   = {asm_q, ld_data};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_ptr_d = word_ptr_q;
    len_d      = len_q;
    asm_d      = asm_q;
    ld_ready_d = ld_ready_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (load_start) begin
          if (load_len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (load_len > DEPTH_L) begin
            err_d = 1'b1;
          end else begin
            state_d    = LOAD;
            word_ptr_d = '0;
            byte_cnt_d = 2'd0;
            len_d      = load_len;
            ld_ready_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0:    asm_d[23:16] = ld_data;
            2'd1:    asm_d[15:8]  = ld_data;
            2'd2:    asm_d[7:0]   = ld_data;
            default: asm_d        = asm_q;
          endcase
          if (word_wr) word_ptr_d = word_ptr_q + 1'b1;
          if (last_word) begin
            state_d    = DONE;
            ld_ready_d = 1'b0;
            done_d     = 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        ld_ready_d = 1'b0;
      end
    endcase
    // Program is valid exactly when the FSM sits in DONE.
    hold_d = (state_d != DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= 2'd0;
      word_ptr_q <= '0;
      len_q      <= '0;
      asm_q      <= '0;
      ld_ready_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_ptr_q <= word_ptr_d;
      len_q      <= len_d;
      asm_q      <= asm_d;
      ld_ready_q <= ld_ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
    end
  end

  // No reset on the array: contents survive a reset.
  always_ff @(posedge clk) begin
    if (word_wr) mem[word_ptr_q] <= wr_word;
  end

  assign widx             = rom_addr[ADDR_W+1:2];
  assign addr_in_range    = (rom_addr[31:ADDR_W+2] == '0);
  assign unused_addr_bits = ^rom_addr[1:0];
  assign rom_inst         = (rom_en && (state_q == DONE) && addr_in_range) ? mem[widx] : '0;

  assign ld_ready  = ld_ready_q;
  assign load_busy = (state_q == LOAD);
  assign load_done = done_q;
  assign load_err  = err_q;
  assign cpu_hold  = hold_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized bench for inst_rom_loader with a word-level memory model and an event/fetch scoreboard.
`timescale 1ns/1ps
module tb_inst_rom_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              rom_en;
  logic [31:0]       rom_addr;
  logic [31:0]       rom_inst;
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_ready;
  logic              load_busy;
  logic              load_done;
  logic              load_err;
  logic              cpu_hold;

  inst_rom_loader #(.ADDR_W(ADDR_W), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .rom_en(rom_en), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .load_start(load_start), .load_len(load_len), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
    .cpu_hold(cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: word contents per address plus "program valid" flag.
  logic [31:0] exp_mem [DEPTH];
  bit          exp_known [DEPTH];
  bit          exp_running = 1'b0;

  int          ev_q[$];          // 1 = load_done, 2 = load_err
  logic [31:0] fetch_q[$];
  logic [7:0]  byte_q[$];

  int hs_cnt = 0;
  int ready_drops = 0;
  bit ready_watch = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) if (ld_valid && ld_ready) hs_cnt <= hs_cnt + 1;
  always @(negedge clk) if (ready_watch && load_busy && !ld_ready) ready_drops <= ready_drops + 1;

  // Monitor: compares every fetch probe and every done/err pulse against queued expectations.
  always @(negedge clk) begin
    logic [31:0] e;
    int k;
    if (fetch_q.size() > 0) begin
      e = fetch_q.pop_front();
      check("fetch", rom_inst, e);
    end
    if (load_done || load_err) begin
      if (ev_q.size() == 0) begin
        check("unexpected_event", {30'b0, load_err, load_done}, 32'h0);
      end else begin
        k = ev_q.pop_front();
        check("event_kind", load_done ? 32'd1 : 32'd2, k);
        if (load_done) check("done_hold", {31'b0, cpu_hold}, 32'h0);
      end
    end
  end

  task automatic fetch(input logic en, input logic [31:0] addr);
    logic [31:0] e;
    @(posedge clk); #1;
    rom_en = en;
    rom_addr = addr;
    e = (en && exp_running && addr[31:ADDR_W+2] == '0) ? exp_mem[addr[ADDR_W+1:2]] : 32'h0;
    fetch_q.push_back(e);
    @(negedge clk); #1;
    rom_en = 1'b0;
  endtask

  task automatic do_load_start(input int len);
    @(negedge clk);
    load_start = 1'b1;
    load_len = (ADDR_W+1)'(len);
    if (len == 0) ev_q.push_back(1);
    else if (len > DEPTH) ev_q.push_back(2);
    @(posedge clk); #1;
    load_start = 1'b0;
    if (len == 0) exp_running = 1'b1;
    else if (len <= DEPTH) exp_running = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data = b;
    while (!ld_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("ready_timeout", 32'd0, 32'd1);
      ld_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      ld_valid = 1'b0;
    end
  endtask

  // Loads len words from byte_q; stops after stop_after bytes (partial load).
  task automatic load_words(input int len, input int gmin, input int gmax, input int stop_after);
    do_load_start(len);
    for (int i = 0; i < len * 4 && i < stop_after; i++) begin
      repeat ($urandom_range(gmax, gmin)) @(negedge clk);
      if (i == len * 4 - 1) ev_q.push_back(1);
      send_byte(byte_q[i]);
      if (i % 4 == 3) begin
        exp_mem[i/4] = {byte_q[i-3], byte_q[i-2], byte_q[i-1], byte_q[i]};
        exp_known[i/4] = 1'b1;
      end
    end
    if (stop_after >= len * 4) exp_running = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int len, base, k;
    rst = 1'b0;
    rom_en = 1'b0;
    rom_addr = 32'h0;
    load_start = 1'b0;
    load_len = '0;
    ld_valid = 1'b0;
    ld_data = 8'h0;
    for (int i = 0; i < DEPTH; i++) exp_known[i] = 1'b0;
    #12;
    check("rst_hold", {31'b0, cpu_hold}, 32'd1);
    check("rst_ready", {31'b0, ld_ready}, 32'd0);
    check("rst_busy", {31'b0, load_busy}, 32'd0);
    check("rst_done_err", {30'b0, load_done, load_err}, 32'd0);
    @(negedge clk); rst = 1'b1;
    fetch(1'b1, 32'h0);
    check("idle_hold", {31'b0, cpu_hold}, 32'd1);

    // Oversized length is refused from IDLE.
    do_load_start(DEPTH + 1);
    @(negedge clk);
    check("err_hold", {31'b0, cpu_hold}, 32'd1);
    check("err_ready", {31'b0, ld_ready}, 32'd0);
    check("err_busy", {31'b0, load_busy}, 32'd0);

    // Two words, back-to-back bytes.
    byte_q = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    load_words(2, 0, 0, 8);
    check("done_on_last_edge", {31'b0, load_done}, 32'd1);
    check("hold_on_last_edge", {31'b0, cpu_hold}, 32'd0);
    check("ready_off_after_done", {31'b0, ld_ready}, 32'd0);
    fetch(1'b1, 32'h4);
    fetch(1'b1, 32'h0);
    fetch(1'b1, 32'h7);

    // Reload from DONE with ld_valid toggling; hold rises after load_start.
    byte_q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    base = hs_cnt;
    k = ready_drops;
    do_load_start(1);
    check("reload_hold_rise", {31'b0, cpu_hold}, 32'd1);
    fetch(1'b1, 32'h0);
    ready_watch = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (1) @(negedge clk);
      if (i == 3) ev_q.push_back(1);
      send_byte(byte_q[i]);
    end
    exp_mem[0] = 32'hDEADBEEF;
    exp_running = 1'b1;
    ready_watch = 1'b0;
    @(negedge clk);
    check("toggle_handshakes", hs_cnt - base, 32'd4);
    check("toggle_ready_steady", ready_drops - k, 32'd0);
    fetch(1'b1, 32'h0);
    fetch(1'b1, 32'h4);

    // Zero-length load completes immediately.
    do_load_start(0);
    @(negedge clk);
    check("len0_hold", {31'b0, cpu_hold}, 32'd0);
    fetch(1'b1, 32'(4 * DEPTH));
    fetch(1'b0, 32'h0);

    // Randomized loads, fetches and refused lengths.
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(6, 1);
      byte_q = {};
      for (int i = 0; i < len * 4; i++) byte_q.push_back(8'($urandom));
      load_words(len, 0, 2, len * 4);
      if ($urandom_range(3, 0) == 0) do_load_start($urandom_range(511, DEPTH + 1));
      for (int f = 0; f < 4; f++) begin
        case ($urandom_range(3, 0))
          0: fetch(1'b0, 32'($urandom_range(len - 1, 0)) << 2);
          1: fetch(1'b1, $urandom | 32'h400);
          default: fetch(1'b1, (32'($urandom_range(len - 1, 0)) << 2) | ($urandom & 32'h3));
        endcase
      end
    end

    // Reset mid-load after 6 bytes of a 3-word load.
    byte_q = {8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18, 8'h29, 8'h3A, 8'h4B, 8'h5C};
    load_words(3, 0, 0, 6);
    @(negedge clk);
    rst = 1'b0;
    exp_running = 1'b0;
    #1;
    check("midrst_hold", {31'b0, cpu_hold}, 32'd1);
    check("midrst_busy", {31'b0, load_busy}, 32'd0);
    check("midrst_ready", {31'b0, ld_ready}, 32'd0);
    @(negedge clk); rst = 1'b1;
    fetch(1'b1, 32'h0);
    do_load_start(0);
    fetch(1'b1, 32'h0);
    fetch(1'b1, 32'h4);

    // One-word reload after reset.
    byte_q = {8'h55, 8'hAA, 8'h0F, 8'hF0};
    load_words(1, 0, 1, 4);
    fetch(1'b1, 32'h0);
    fetch(1'b1, 32'h4);

    repeat (3) @(negedge clk);
    check("events_drained", ev_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
